// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state/class enums, opcode constants and ALU function codes
//   state_t     sequencer states
//   op_class_t  instruction classes produced by op_class_decode
package cpu_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;
    typedef enum logic [2:0] {
        C_PUSH, C_ALU, C_RET, C_BR, C_CALL, C_HALT, C_ILL
    } op_class_t;
    localparam logic [3:0] CLS_SYS  = 4'd0;
    localparam logic [3:0] CLS_CALL = 4'd10;
    localparam logic [3:0] CLS_HALT = 4'd15;
    localparam logic [2:0] SUB_RET  = 3'd6;
    localparam logic [2:0] FN_ADD   = 3'd2;
    localparam logic [2:0] FN_PASS  = 3'd6;
endpackage

// File: rtl/op_class_decode.sv
// op_class_decode: combinational instruction class decoder
//   op  in   ir[15:9] (class in op[6:3], sub-op in op[2:0])
//   cls out  decoded instruction class
module op_class_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output op_class_t  cls
);
    logic [3:0] c;
    logic [2:0] s;
    assign c = op[6:3];
    assign s = op[2:0];
    assign cls = c == CLS_SYS  ? (s == 3'd0 ? C_PUSH : s == SUB_RET ? C_RET : C_ALU) :
                 c == CLS_CALL ? C_CALL :
                 c == CLS_HALT ? C_HALT :
                 c >  CLS_CALL ? C_ILL  : C_BR;
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: Moore control FSM for a multicycle CPU datapath
//   clk, rst_n                 clock, async active-low reset
//   start, ir, cond_true       start request, instruction register, branch condition
//   mem_ready                  data-memory access complete
//   ld_ir, ld_pc, pc_sel       IR load, PC load, PC source (0 = PC+1, 1 = R)
//   tpcX,tRDM,tregY,tlab,treg,tpc  bus driver enables (X, Y, D_bus)
//   RDM,spSel,inc,ldsp,WRR,fn  memory read/write, SP control, reg write, ALU function
//   busy, halted, illegal      status flags
module multicycle_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] ir,
    input  logic        cond_true,
    input  logic        mem_ready,
    output logic        ld_ir,
    output logic        ld_pc,
    output logic        pc_sel,
    output logic        tpcX,
    output logic        tRDM,
    output logic        tregY,
    output logic        tlab,
    output logic        treg,
    output logic        tpc,
    output logic        RDM,
    output logic        spSel,
    output logic        inc,
    output logic        ldsp,
    output logic        WRR,
    output logic [2:0]  fn,
    output logic        busy,
    output logic        halted,
    output logic        illegal
);
    state_t     state, state_nx;
    op_class_t  cls, dec_cls;
    logic [2:0] sub_op;
    logic       cond_r;
    logic       unused_ir;

    assign unused_ir = ^ir[8:0];

    op_class_decode u_dec (.op(ir[15:9]), .cls(dec_cls));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cls    <= C_PUSH;
            sub_op <= 3'd0;
            cond_r <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) begin
                cls    <= dec_cls;
                sub_op <= ir[11:9];
            end
            if (state == S_EXEC) cond_r <= cond_true;
        end
    end

    always_comb begin
        state_nx = state;
        ld_ir    = 1'b0;
        ld_pc    = 1'b0;
        pc_sel   = 1'b0;
        tpcX     = 1'b0;
        tRDM     = 1'b0;
        tregY    = 1'b0;
        tlab     = 1'b0;
        treg     = 1'b0;
        tpc      = 1'b0;
        RDM      = 1'b1;
        spSel    = 1'b0;
        inc      = 1'b0;
        ldsp     = 1'b0;
        WRR      = 1'b0;
        fn       = 3'd0;
        halted   = 1'b0;
        illegal  = 1'b0;
        busy     = state != S_IDLE && state != S_HALT;
        case (state)
            S_IDLE:   state_nx = start ? S_FETCH : S_IDLE;
            S_FETCH: begin
                ld_ir    = 1'b1;
                ld_pc    = 1'b1;
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                // IR is already loaded and stable here, so the live decode is used for the one-cycle illegal pulse
                illegal  = dec_cls == C_ILL;
                state_nx = dec_cls == C_HALT ? S_HALT :
                           dec_cls == C_ILL  ? S_FETCH :
                           (dec_cls == C_ALU || dec_cls == C_BR) ? S_EXEC : S_MEM;
            end
            S_MEM: begin
                if (cls == C_RET) begin
                    tRDM = 1'b1;
                    fn   = FN_PASS;
                end else begin
                    // push: the write strobe and SP update fire only on the completing cycle
                    spSel = 1'b1;
                    treg  = cls == C_PUSH;
                    tpc   = cls == C_CALL;
                    RDM   = !mem_ready;
                    ldsp  = mem_ready;
                end
                state_nx = !mem_ready      ? S_MEM   :
                           cls == C_PUSH   ? S_FETCH :
                           cls == C_RET    ? S_WB    : S_EXEC;
            end
            S_EXEC: begin
                tRDM     = cls == C_ALU;
                tregY    = cls == C_ALU;
                tpcX     = cls != C_ALU;
                tlab     = cls != C_ALU;
                fn       = cls == C_ALU ? sub_op : FN_ADD;
                state_nx = S_WB;
            end
            S_WB: begin
                WRR      = cls == C_ALU;
                inc      = cls == C_ALU || cls == C_RET;
                ldsp     = cls == C_ALU || cls == C_RET;
                ld_pc    = cls == C_RET || cls == C_CALL || (cls == C_BR && cond_r);
                pc_sel   = ld_pc;
                state_nx = S_FETCH;
            end
            S_HALT:   halted = 1'b1;
            default:  state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: scoreboard bench for multicycle_sequencer
//   the driver pushes a per-instruction summary (latency and pulse counts) from a reference model,
//   the monitor accumulates the same summary from DUT outputs between ld_ir pulses and compares
module tb_multicycle_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, start, cond_true, mem_ready;
    logic [15:0] ir;
    logic        ld_ir, ld_pc, pc_sel, tpcX, tRDM, tregY, tlab, treg, tpc;
    logic        RDM, spSel, inc, ldsp, WRR, busy, halted, illegal;
    logic [2:0]  fn;
    logic [19:0] outs;

    typedef struct packed {
        logic [7:0] cyc;
        logic [3:0] ldsp, wrr, jmp, pcinc, wr, ill, inc;
        logic [2:0] fn;
    } rec_t;

    localparam logic [19:0] RST_VEC = 20'h00400;

    rec_t exp_q[$];
    rec_t acc;
    bit   open, mon_en;
    int   compared, mismatched, n_instr;
    int   sub_tab[6] = '{1, 2, 3, 4, 5, 7};

    multicycle_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ir(ir), .cond_true(cond_true),
        .mem_ready(mem_ready), .ld_ir(ld_ir), .ld_pc(ld_pc), .pc_sel(pc_sel),
        .tpcX(tpcX), .tRDM(tRDM), .tregY(tregY), .tlab(tlab), .treg(treg), .tpc(tpc),
        .RDM(RDM), .spSel(spSel), .inc(inc), .ldsp(ldsp), .WRR(WRR), .fn(fn),
        .busy(busy), .halted(halted), .illegal(illegal)
    );

    assign outs = {ld_ir, ld_pc, pc_sel, tpcX, tRDM, tregY, tlab, treg, tpc,
                   RDM, spSel, inc, ldsp, WRR, fn, busy, halted, illegal};

    always #5 clk = ~clk;

    function automatic rec_t model(input logic [15:0] i, input int w, input bit cv);
        int   c = int'(i[15:12]);
        int   s = int'(i[11:9]);
        rec_t r = '0;
        r.pcinc = 4'd1;
        if (i[15:9] == 7'd0) begin
            r.cyc = 8'(3 + w); r.ldsp = 1; r.wr = 1;
        end else if (c == 0 && s == 6) begin
            r.cyc = 8'(4 + w); r.ldsp = 1; r.jmp = 1; r.inc = 1; r.fn = 3'd6;
        end else if (c == 0) begin
            r.cyc = 8'd4; r.ldsp = 1; r.wrr = 1; r.inc = 1; r.fn = 3'(s);
        end else if (c <= 9) begin
            r.cyc = 8'd4; r.jmp = 4'(cv); r.fn = 3'd2;
        end else if (c == 10) begin
            r.cyc = 8'(5 + w); r.ldsp = 1; r.wr = 1; r.jmp = 1; r.fn = 3'd2;
        end else if (c == 15) begin
            r.cyc = 8'd2;
        end else begin
            r.cyc = 8'd2; r.ill = 1;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [19:0] got, input logic [19:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic run_instr(input logic [15:0] i, input int w, input bit cv);
        rec_t e = model(i, w, cv);
        exp_q.push_back(e);
        ir = i;
        for (int c = 0; c < int'(e.cyc); c++) begin
            mem_ready = !(c >= 2 && c < 2 + w);
            cond_true = (c == 2) ? cv : !cv;
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (open && (ld_ir || halted)) begin
                rec_t e;
                open = 1'b0;
                compared++;
                n_instr++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL instr %0d: got %h required nothing queued", n_instr, acc);
                end else begin
                    e = exp_q.pop_front();
                    if (acc !== e) begin
                        mismatched++;
                        $display("FAIL instr %0d: got %h required %h", n_instr, acc, e);
                    end
                end
            end
            if (ld_ir) begin
                open = 1'b1;
                acc  = '0;
            end
            if (open) begin
                acc.cyc = acc.cyc + 1;
                if (ldsp) acc.ldsp = acc.ldsp + 1;
                if (WRR) acc.wrr = acc.wrr + 1;
                if (ld_pc && pc_sel) acc.jmp = acc.jmp + 1;
                if (ld_pc && !pc_sel) acc.pcinc = acc.pcinc + 1;
                if (!RDM) acc.wr = acc.wr + 1;
                if (illegal) acc.ill = acc.ill + 1;
                if (inc) acc.inc = acc.inc + 1;
                if (fn != 3'd0) acc.fn = fn;
            end
        end
    end

    always @(negedge clk) begin
        compared++;
        if ((tpcX && tRDM) || (tregY && tlab) || (treg && tpc)) begin
            mismatched++;
            $display("FAIL bus_excl: got X=%b%b Y=%b%b D=%b%b required at most one per bus",
                     tpcX, tRDM, tregY, tlab, treg, tpc);
        end
    end

    initial begin
        logic [15:0] i;
        int          w;
        bit          cv;
        rst_n = 1'b0; start = 1'b0; ir = 16'h0; cond_true = 1'b0; mem_ready = 1'b1;
        mon_en = 1'b0; open = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", outs, RST_VEC);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_no_start", outs, RST_VEC);
        start = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        run_instr(16'h0000, 0, 1'b0);
        run_instr(16'h0400, 0, 1'b0);
        run_instr(16'h4005, 0, 1'b0);
        run_instr(16'h4005, 0, 1'b1);
        run_instr(16'hA003, 3, 1'b0);
        run_instr(16'hB000, 0, 1'b0);
        run_instr(16'h0C12, 2, 1'b1);
        for (int n = 0; n < 80; n++) begin
            w  = 0;
            cv = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: begin i = {7'd0, 9'($urandom)}; w = $urandom_range(0, 3); end
                1: i = {4'd0, 3'(sub_tab[$urandom_range(0, 5)]), 9'($urandom)};
                2: begin i = {4'd0, 3'd6, 9'($urandom)}; w = $urandom_range(0, 3); end
                3: i = {4'($urandom_range(1, 9)), 12'($urandom)};
                4: begin i = {4'd10, 12'($urandom)}; w = $urandom_range(0, 3); end
                default: i = {4'($urandom_range(11, 14)), 12'($urandom)};
            endcase
            run_instr(i, w, cv);
        end
        run_instr(16'hF000, 0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            start = 1'(k);
            @(posedge clk);
            #1;
            check("halt_persist", {18'd0, halted, busy}, 20'd2);
        end
        mon_en = 1'b0;
        start = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("halt_reset", outs, RST_VEC);
        rst_n = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ir = 16'hA003;
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("call_mem_hold", {17'd0, tpc, ldsp, RDM}, 20'b101);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs, RST_VEC);
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("reset_hold", outs, RST_VEC);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", outs, RST_VEC);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL leftover: got %0d queued required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: leave IDLE and begin fetching.
REQ-004 SHALL have port ir, input, 16 bits: fetched instruction; ir[15:12] is the class, ir[11:9] is the sub-op.
REQ-005 SHALL have port cond_true, input, 1 bit: branch condition from the status-select logic, valid in EXEC.
REQ-006 SHALL have port mem_ready, input, 1 bit: data-memory access complete.
REQ-007 SHALL have port ld_ir, output, 1 bit: capture instruction memory into IR.
REQ-008 SHALL have port ld_pc, output, 1 bit: load PC.
REQ-009 SHALL have port pc_sel, output, 1 bit: PC source, 0 = PC+1 and 1 = ALU result R.
REQ-010 SHALL have ports tpcX, tRDM, tregY, tlab, treg and tpc, outputs, 1 bit each: tri-state bus enables for the X, Y and D_bus drivers.
REQ-011 SHALL have ports RDM, spSel, inc, ldsp and WRR, outputs, 1 bit each: memory read (1) or write (0), SP mux select, SP +1 (1) or -1 (0), SP load, register write.
REQ-012 SHALL have port fn, output, 3 bits: ALU function code.
REQ-013 SHALL have ports busy, halted and illegal, outputs, 1 bit each: status flags.

Function
REQ-014 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-015 SHALL drive all outputs as Moore outputs: a function of the registered state and the class latched in DECODE only, never of ir directly.
REQ-016 SHALL go IDLE->FETCH on start=1 and otherwise stay in IDLE.
REQ-017 SHALL, in FETCH, assert ld_ir=1 and ld_pc=1 with pc_sel=0, then go to DECODE.
REQ-018 SHALL, in DECODE, latch the class as follows:
- PUSH: ir[15:9]=0.
- ALU: class 0, sub-op not 0 and not 6.
- RET: class 0, sub-op 6.
- BR: class 1..9.
- CALL: class 10.
- HALT: class 15.
- ILL: class 11..14.
REQ-019 SHALL sequence PUSH as DECODE->MEM; MEM drives treg=1, spSel=1, RDM=0, inc=0, ldsp=1.
REQ-020 SHALL sequence ALU as DECODE->EXEC->WB:
- EXEC drives tRDM=1, tregY=1, RDM=1 and fn=ir[11:9].
- WB drives WRR=1, inc=1 and ldsp=1.
REQ-021 SHALL sequence RET as DECODE->MEM->WB:
- MEM drives RDM=1, tRDM=1 and fn=6 (pass X).
- WB drives ld_pc=1, pc_sel=1, inc=1 and ldsp=1.
REQ-022 SHALL sequence BR as DECODE->EXEC->WB:
- EXEC drives tpcX=1, tlab=1 and fn=2 (add), and samples cond_true.
- WB drives ld_pc=1 with pc_sel=1 only if the sampled cond_true was 1.
REQ-023 SHALL sequence CALL as DECODE->MEM->EXEC->WB:
- MEM drives tpc=1, spSel=1, RDM=0, inc=0 and ldsp=1.
- EXEC and WB are as for BR, with the branch taken unconditionally.
REQ-024 SHALL make MEM hold until mem_ready=1; ldsp and the RDM=0 write strobe assert only in the exit cycle of MEM.
REQ-025 SHALL transition DECODE->HALT for the HALT class; HALT drives halted=1 and exits only via reset (start is ignored).
REQ-026 SHALL, for the ILL class, pulse illegal=1 for one cycle in DECODE and return to FETCH as a NOP.
REQ-027 SHALL return every instruction to FETCH after its last state (WB or MEM).
REQ-028 SHALL assert at most one of {tpcX, tRDM} on X, at most one of {tregY, tlab} on Y, and at most one of {treg, tpc} on D_bus in every cycle.
REQ-029 SHALL drive busy=1 in every state except IDLE and HALT.
REQ-030 SHALL fix instruction latency (mem_ready=1) as: PUSH 3, ALU 4, RET 4, BR 4, CALL 5, ILL 2 cycles.

Reset
REQ-031 SHALL, while rst_n=0, force state=IDLE and drive all enables, ld_*, WRR, ldsp, busy, halted and illegal to 0, with RDM=1, fn=0, pc_sel=0, inc=0 and spSel=0.
REQ-032 SHALL, on reset mid-instruction, abort the instruction with no further ld_pc, ldsp or WRR pulse.

Structure
REQ-033 SHALL place the state enum, class enum, class opcodes (0, 10, 15) and fn codes (ADD=2, PASS=6) in shared package cpu_ctrl_pkg.
REQ-034 SHALL implement class decoding as combinational sub-module op_class_decode (ir[15:9] -> class).

Verification
REQ-035 SHALL be verified by these directed scenarios:
- PUSH ir=16'h0000 with mem_ready=1: FETCH, DECODE, MEM; in MEM treg=1, RDM=0, ldsp=1, inc=0; back to FETCH on cycle 4.
- ALU ir=16'h0400 (sub-op 2): EXEC fn=2 with tRDM and tregY set; WB has WRR=1, ldsp=1, inc=1.
- BR ir=16'h4005 with cond_true=0 gives no ld_pc in WB; with cond_true=1, ld_pc=1 and pc_sel=1 in WB.
- CALL ir=16'hA003 with mem_ready low for 3 cycles: MEM held 4 cycles; ldsp pulses exactly once; latency is 8.
- ILL ir=16'hB000: illegal pulses 1 cycle; HALT ir=16'hF000: halted=1 and busy=0 persist while start toggles.
- rst_n low during CALL's MEM: outputs reach reset values immediately and asynchronously; no ldsp.
- Bus-exclusivity assertion (REQ-028) checked every cycle of a random instruction stream.
